// File: rtl/uart_tx.sv
// UART transmitter: 5-8 data bits sent LSB first, optional parity, 1 or 2 stop bits, gated by cts_n.
// Build with UART_TX_BREAK_EN defined to add the break_i input, which holds the line low while idle.
module uart_tx #(
   parameter int TICKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_tick,
   input  logic [1:0]  data_bit_num_i,
   input  logic        parity_en_i,
   input  logic        parity_type_i,
   input  logic        stop_bit_num_i,
   input  logic [31:0] tx_data_i,
   input  logic        tx_start_i,
`ifdef UART_TX_BREAK_EN
   input  logic        break_i,
`endif
   output logic        tx_busy_o,
   output logic        tx_done_o,
   input  logic        cts_n,
   output logic        tx
);

   // state     | meaning
   // TX_IDLE   | line high (or low during break), waiting for a request and clear-to-send
   // TX_START  | start bit, line low
   // TX_DATA   | data bit bit_cnt of the shadowed character
   // TX_PARITY | parity bit over the N data bits
   // TX_STOP   | stop bit(s), line high
   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   localparam int TW = (TICKS_PER_BIT > 2) ? $clog2(TICKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);

   tx_state_t     state, state_nxt;
   logic          cts_meta, cts_s;
   logic          pending;
   logic [TW-1:0] tick_cnt, tick_nxt;
   logic [2:0]    bit_cnt, bit_cnt_nxt;
   logic [7:0]    shd_data;
   logic [1:0]    shd_len;
   logic          shd_pen, shd_ptype, shd_stop;

   logic          accept, launch_ok, launch, frame_end, bit_end;
   logic [2:0]    last_data;
   logic [7:0]    data_mask;
   logic          par_bit;
   logic          tx_nxt;
   logic          break_hold;

   // Only the low byte of the character bus is transmitted.
   logic unused_data_hi;
   assign unused_data_hi = ^tx_data_i[31:8];

`ifdef UART_TX_BREAK_EN
   assign break_hold = break_i;
`else
   assign break_hold = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cts_meta <= 1'b1;
         cts_s    <= 1'b1;
      end else begin
         cts_meta <= cts_n;
         cts_s    <= cts_meta;
      end
   end

   assign accept    = tx_start_i && (state == TX_IDLE) && !pending;
   assign launch_ok = pending && !cts_s && !break_hold;
   assign bit_end   = tx_tick && (tick_cnt == TICK_LAST);
   assign last_data = {1'b0, shd_len} + 3'd4;

   always_comb begin
      data_mask = 8'hFF;
      case (shd_len)
         2'b00:   data_mask = 8'h1F;
         2'b01:   data_mask = 8'h3F;
         2'b10:   data_mask = 8'h7F;
         default: data_mask = 8'hFF;
      endcase
   end

   // parity type 0 = odd, 1 = even
   assign par_bit = (^(shd_data & data_mask)) ^ ~shd_ptype;

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      tick_nxt    = tick_cnt;
      launch      = 1'b0;
      frame_end   = 1'b0;
      case (state)
         TX_IDLE: begin
            tick_nxt    = '0;
            bit_cnt_nxt = 3'd0;
            if (launch_ok) begin
               state_nxt = TX_START;
               launch    = 1'b1;
            end
         end
         TX_START: begin
            if (bit_end) begin
               state_nxt   = TX_DATA;
               bit_cnt_nxt = 3'd0;
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               if (bit_cnt == last_data) begin
                  state_nxt   = shd_pen ? TX_PARITY : TX_STOP;
                  bit_cnt_nxt = 3'd0;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end
         end
         TX_PARITY: begin
            if (bit_end) begin
               state_nxt   = TX_STOP;
               bit_cnt_nxt = 3'd0;
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               if (bit_cnt == {2'b00, shd_stop}) begin
                  state_nxt   = TX_IDLE;
                  bit_cnt_nxt = 3'd0;
                  frame_end   = 1'b1;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end
         end
         default: begin
            state_nxt   = TX_IDLE;
            bit_cnt_nxt = 3'd0;
         end
      endcase
      if ((state != TX_IDLE) && tx_tick)
         tick_nxt = bit_end ? '0 : tick_cnt + TW'(1);
   end

   // Line value follows the next state so tx changes on the same clk as the state.
   always_comb begin
      tx_nxt = 1'b1;
      case (state_nxt)
         TX_IDLE:   tx_nxt = ~break_hold;
         TX_START:  tx_nxt = 1'b0;
         TX_DATA:   tx_nxt = shd_data[bit_cnt_nxt];
         TX_PARITY: tx_nxt = par_bit;
         TX_STOP:   tx_nxt = 1'b1;
         default:   tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= TX_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= 3'd0;
         pending   <= 1'b0;
         tx        <= 1'b1;
         tx_busy_o <= 1'b0;
         tx_done_o <= 1'b0;
      end else begin
         state    <= state_nxt;
         tick_cnt <= tick_nxt;
         bit_cnt  <= bit_cnt_nxt;
         tx       <= tx_nxt;
         if (accept)
            pending <= 1'b1;
         else if (launch)
            pending <= 1'b0;
         if (accept) begin
            tx_busy_o <= 1'b1;
            tx_done_o <= 1'b0;
         end else if (frame_end) begin
            tx_busy_o <= 1'b0;
            tx_done_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shd_data  <= 8'h00;
         shd_len   <= 2'b00;
         shd_pen   <= 1'b0;
         shd_ptype <= 1'b0;
         shd_stop  <= 1'b0;
      end else if (accept) begin
         shd_data  <= tx_data_i[7:0];
         shd_len   <= data_bit_num_i;
         shd_pen   <= parity_en_i;
         shd_ptype <= parity_type_i;
         shd_stop  <= stop_bit_num_i;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: random and directed frames compared against a bit-list model.
module tb_uart_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tx_tick = 1'b0;
   logic [1:0]  data_bit_num_i = 2'b00;
   logic        parity_en_i = 1'b0;
   logic        parity_type_i = 1'b0;
   logic        stop_bit_num_i = 1'b0;
   logic [31:0] tx_data_i = 32'h0;
   logic        tx_start_i = 1'b0;
   logic        cts_n = 1'b0;
`ifdef UART_TX_BREAK_EN
   logic        break_i = 1'b0;
`endif
   logic        tx_busy_o, tx_done_o, tx;

   int n_cmp = 0;
   int n_err = 0;
   logic exp_q[$];

   uart_tx #(.TICKS_PER_BIT(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .tx_tick        (tx_tick),
      .data_bit_num_i (data_bit_num_i),
      .parity_en_i    (parity_en_i),
      .parity_type_i  (parity_type_i),
      .stop_bit_num_i (stop_bit_num_i),
      .tx_data_i      (tx_data_i),
      .tx_start_i     (tx_start_i),
`ifdef UART_TX_BREAK_EN
      .break_i        (break_i),
`endif
      .tx_busy_o      (tx_busy_o),
      .tx_done_o      (tx_done_o),
      .cts_n          (cts_n),
      .tx             (tx)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_tick();
      @(negedge clk) tx_tick = 1'b1;
      @(negedge clk) tx_tick = 1'b0;
   endtask

   // Expected line bits: start, data LSB first, parity, stop bits.
   task automatic build_exp(input logic [7:0] d, input int n, input logic pen,
                            input logic ptype, input int nstop);
      int ones;
      ones = 0;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (pen)
         exp_q.push_back(ptype ? ((ones % 2) == 1) : ((ones % 2) == 0));
      for (int s = 0; s < nstop; s++)
         exp_q.push_back(1'b1);
   endtask

   task automatic request(input string name, input logic [31:0] d, input logic [1:0] code,
                          input logic pen, input logic ptype, input logic stp, input logic cts_val);
      cts_n = cts_val;
      repeat (3) @(negedge clk);
      tx_data_i      = d;
      data_bit_num_i = code;
      parity_en_i    = pen;
      parity_type_i  = ptype;
      stop_bit_num_i = stp;
      tx_start_i     = 1'b1;
      @(negedge clk) tx_start_i = 1'b0;
      build_exp(d[7:0], int'(code) + 5, pen, ptype, int'(stp) + 1);
      n_cmp++;
      if (tx_busy_o !== 1'b1 || tx_done_o !== 1'b0) begin
         n_err++;
         $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", name, tx_busy_o, tx_done_o);
      end
   endtask

   task automatic run_frame(input string name);
      int w;
      w = 0;
      while (tx !== 1'b0 && w < 4) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (tx !== 1'b0) begin
         n_err++;
         $display("FAIL %s launch: tx=%b after %0d clk, required 0", name, tx, w);
         return;
      end
      // Inputs wander after launch; only the captured copies may matter.
      data_bit_num_i = 2'($urandom);
      tx_data_i      = $urandom;
      parity_en_i    = 1'($urandom);
      parity_type_i  = 1'($urandom);
      stop_bit_num_i = 1'($urandom);
      cts_n          = 1'($urandom);
      for (int i = 0; i < exp_q.size(); i++) begin
         repeat (8) do_tick();
         n_cmp++;
         if (tx !== exp_q[i]) begin
            n_err++;
            $display("FAIL %s bit%0d: tx=%b, required %b", name, i, tx, exp_q[i]);
         end
         if (i == 1) begin
            tx_data_i = ~tx_data_i;
            @(negedge clk) tx_start_i = 1'b1;
            @(negedge clk) tx_start_i = 1'b0;
         end
         if (i == exp_q.size() - 1) begin
            repeat (7) do_tick();
            n_cmp++;
            if (tx_busy_o !== 1'b1 || tx_done_o !== 1'b0) begin
               n_err++;
               $display("FAIL %s before_last_tick: busy=%b done=%b, required busy=1 done=0",
                        name, tx_busy_o, tx_done_o);
            end
            @(negedge clk) begin
               tx_tick    = 1'b1;
               tx_start_i = 1'b1;
            end
            @(negedge clk) begin
               tx_tick    = 1'b0;
               tx_start_i = 1'b0;
            end
         end else begin
            repeat (8) do_tick();
         end
      end
      n_cmp++;
      if (tx_done_o !== 1'b1 || tx_busy_o !== 1'b0 || tx !== 1'b1) begin
         n_err++;
         $display("FAIL %s end: done=%b busy=%b tx=%b, required done=1 busy=0 tx=1",
                  name, tx_done_o, tx_busy_o, tx);
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (tx_busy_o !== 1'b0 || tx_done_o !== 1'b1 || tx !== 1'b1) begin
         n_err++;
         $display("FAIL %s after_end: busy=%b done=%b tx=%b, required busy=0 done=1 tx=1",
                  name, tx_busy_o, tx_done_o, tx);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1 || tx_busy_o !== 1'b0 || tx_done_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset: tx=%b busy=%b done=%b, required 1/0/0", tx, tx_busy_o, tx_done_o);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_8n1();
      request("8n1", 32'h000000A5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame("8n1");
   endtask

   task automatic test_parity();
      request("5o1", 32'h00000013, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      run_frame("5o1");
      request("5e1", 32'h00000013, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      run_frame("5e1");
      request("7e2", 32'h0000007F, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
      run_frame("7e2");
   endtask

   task automatic test_cts();
      int bad;
      int w;
      bad = 0;
      request("cts", $urandom, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 1000; i++) begin
         do_tick();
         if (tx !== 1'b1 || tx_busy_o !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL cts_hold: %0d ticks with tx!=1 or busy!=1, required 0", bad);
      end
      cts_n = 1'b0;
      w = 0;
      while (tx !== 1'b0 && w < 6) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (w > 3) begin
         n_err++;
         $display("FAIL cts_release: start bit after %0d clk, required <= 3", w);
      end
      run_frame("cts");
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++)
         begin
            request("rand", $urandom, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            run_frame("rand");
         end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] d;
      d = $urandom & 32'hFFFF_FFF7;
      request("rst_mid", d, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      repeat (72) do_tick();
      n_cmp++;
      if (tx !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_bit3: tx=%b, required 0", tx);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (tx !== 1'b1 || tx_busy_o !== 1'b0 || tx_done_o !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid: tx=%b busy=%b done=%b, required 1/0/0", tx, tx_busy_o, tx_done_o);
      end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      request("post_rst", $urandom, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
      run_frame("post_rst");
   endtask

`ifdef UART_TX_BREAK_EN
   task automatic test_break();
      break_i = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (tx !== 1'b0) begin
         n_err++;
         $display("FAIL break_low: tx=%b, required 0", tx);
      end
      repeat (50) do_tick();
      request("break", $urandom, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (20) do_tick();
      n_cmp++;
      if (tx !== 1'b0 || tx_busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL break_hold: tx=%b busy=%b, required tx=0 busy=1", tx, tx_busy_o);
      end
      break_i = 1'b0;
      run_frame("break");
      break_i = 1'b1;
      repeat (3) @(negedge clk);
      break_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1) begin
         n_err++;
         $display("FAIL break_release: tx=%b, required 1", tx);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_cts();
      test_random();
      test_reset_midframe();
`ifdef UART_TX_BREAK_EN
      test_break();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
